name_component_assembler: RTL and testbench

NAME_COMPONENT_ASSEMBLER -- requirements
Module: name_component_assembler

---
 rtl/name_component_assembler.sv | 130 +++++++++++++
 tb/tb_name_component_assembler.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/name_component_assembler.sv
// Assembles a stream of name component words into one fixed-width name record.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
module name_component_assembler #(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_NAME_LENGTH = 8,
    parameter int LEN_SIZE        = 4
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic                                 comp_valid_in,
    input  logic [WORD_SIZE-1:0]                 comp_word_in,
    input  logic                                 comp_last_in,
    output logic                                 comp_ready_out,
    output logic                                 name_valid_out,
    output logic [WORD_SIZE*MAX_NAME_LENGTH-1:0] name_words_out,
    output logic [LEN_SIZE-1:0]                  name_len_out,
    output logic                                 name_overflow_out,
    input  logic                                 name_ready_in,
    output logic [1:0]                           state_dbg_out
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                                 state_q;
    state_t                                 state_d;
    logic                                   ready_en_q;
    logic [WORD_SIZE-1:0]                   slot_q [MAX_NAME_LENGTH];
    logic [LEN_SIZE-1:0]                    wr_idx_q;
    logic [LEN_SIZE-1:0]                    len_q;
    logic                                   ovf_q;
    logic [WORD_SIZE*MAX_NAME_LENGTH-1:0]   masked_words;
    logic                                   word_xfer;
    logic                                   collect_xfer;
    logic                                   last_slot;
    logic                                   move;

    assign state_dbg_out = state_q;
    assign word_xfer     = comp_valid_in && comp_ready_out;
    assign collect_xfer  = word_xfer && (state_q == COLLECT);
    assign last_slot     = (wr_idx_q == LEN_SIZE'(MAX_NAME_LENGTH - 1));
    // The output register is free when empty or being consumed on this same edge.
    assign move          = (state_q == HOLD) && (!name_valid_out || name_ready_in);

    always_comb begin
        state_d        = state_q;
        comp_ready_out = ready_en_q && (state_q != HOLD);
        case (state_q)
            COLLECT: begin
                if (word_xfer) begin
                    if (comp_last_in)   state_d = HOLD;
                    else if (last_slot) state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (word_xfer && comp_last_in) state_d = HOLD;
            end
            HOLD: begin
                if (move) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        masked_words = '0;
        for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
            masked_words[k*WORD_SIZE +: WORD_SIZE] = (LEN_SIZE'(k) < len_q) ? slot_q[k] : '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= COLLECT;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    // Assembly buffer: cleared as a whole when its contents move to the output register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < MAX_NAME_LENGTH; k++) slot_q[k] <= '0;
            wr_idx_q <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
                if (move) begin
                    slot_q[k] <= '0;
                end else if (collect_xfer && (wr_idx_q == LEN_SIZE'(k))) begin
                    slot_q[k] <= comp_word_in;
                end
            end
            if (move) begin
                wr_idx_q <= '0;
                len_q    <= '0;
                ovf_q    <= 1'b0;
            end else if (collect_xfer) begin
                wr_idx_q <= wr_idx_q + LEN_SIZE'(1);
                if (comp_last_in)   len_q <= wr_idx_q + LEN_SIZE'(1);
                else if (last_slot) ovf_q <= 1'b1;
            end else if (word_xfer && (state_q == DISCARD) && comp_last_in) begin
                len_q <= LEN_SIZE'(MAX_NAME_LENGTH);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            name_valid_out    <= 1'b0;
            name_words_out    <= '0;
            name_len_out      <= '0;
            name_overflow_out <= 1'b0;
        end else if (move) begin
            name_valid_out    <= 1'b1;
            name_words_out    <= masked_words;
            name_len_out      <= len_q;
            name_overflow_out <= ovf_q;
        end else if (name_valid_out && name_ready_in) begin
            name_valid_out    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_name_component_assembler.sv
// Bench for name_component_assembler: scenario tasks plus a consume-side scoreboard
// fed by a list-level model of what each offered name should become.
module tb_name_component_assembler;

    localparam int W  = 32;
    localparam int M  = 8;
    localparam int L  = 4;
    localparam int NW = W * M;
    localparam int EW = NW + L + 1;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic            comp_valid_in;
    logic [W-1:0]    comp_word_in;
    logic            comp_last_in;
    logic            comp_ready_out;
    logic            name_valid_out;
    logic [NW-1:0]   name_words_out;
    logic [L-1:0]    name_len_out;
    logic            name_overflow_out;
    logic            name_ready_in;
    logic [1:0]      state_dbg_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];
    int consume_cyc_q[$];

    name_component_assembler #(.WORD_SIZE(W), .MAX_NAME_LENGTH(M), .LEN_SIZE(L)) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .comp_valid_in(comp_valid_in),
        .comp_word_in(comp_word_in),
        .comp_last_in(comp_last_in),
        .comp_ready_out(comp_ready_out),
        .name_valid_out(name_valid_out),
        .name_words_out(name_words_out),
        .name_len_out(name_len_out),
        .name_overflow_out(name_overflow_out),
        .name_ready_in(name_ready_in),
        .state_dbg_out(state_dbg_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Reference: the first M words survive, the rest read zero; longer lists are flagged.
    function automatic logic [EW-1:0] model(input logic [W-1:0] w[$]);
        logic [NW-1:0] words;
        int n;
        int len;
        words = '0;
        n = w.size();
        for (int k = 0; k < n && k < M; k++) words[k*W +: W] = w[k];
        len = (n > M) ? M : n;
        return {words, L'(len), (n > M)};
    endfunction

    logic          prev_hold = 1'b0;
    logic [EW-1:0] prev_out;

    always @(negedge clk_in) begin
        logic [EW-1:0] cur;
        logic [EW-1:0] exp;
        cur = {name_words_out, name_len_out, name_overflow_out};
        if (rst_n_in !== 1'b1) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (cur !== prev_out) begin
                    errors++;
                    $display("FAIL hold_stable got=%h required=%h", cur, prev_out);
                end
            end
            if (name_valid_out && name_ready_in) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_name got=%h required=none", cur);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur !== exp) begin
                        errors++;
                        $display("FAIL name got=%h required=%h", cur, exp);
                    end
                    consume_cyc_q.push_back(cyc);
                end
            end
            prev_hold = name_valid_out && !name_ready_in;
            prev_out  = cur;
        end
    end

    task automatic drive_word(input logic [W-1:0] w, input logic last, input bit gaps, output int stalls);
        stalls = 0;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
                comp_valid_in = 1'b0;
                comp_word_in  = $urandom;
                comp_last_in  = 1'($urandom_range(0, 1));
                name_ready_in = 1'($urandom_range(0, 1));
                @(posedge clk_in); #1;
            end
        end
        comp_valid_in = 1'b1;
        comp_word_in  = w;
        comp_last_in  = last;
        while (comp_ready_out !== 1'b1 && stalls < 40) begin
            if (gaps) name_ready_in = 1'($urandom_range(0, 1));
            @(posedge clk_in); #1;
            stalls++;
        end
        if (stalls >= 40) begin
            checks++;
            errors++;
            $display("FAIL word_accept_timeout got=ready_%b required=ready_1", comp_ready_out);
        end
        @(posedge clk_in); #1;
        comp_valid_in = 1'b0;
        comp_word_in  = $urandom;
        comp_last_in  = 1'($urandom_range(0, 1));
    endtask

    task automatic send_name(input logic [W-1:0] w[$], input bit gaps, input bit push, output int stalls);
        int st;
        stalls = 0;
        if (push) exp_q.push_back(model(w));
        for (int i = 0; i < w.size(); i++) begin
            drive_word(w[i], (i == w.size() - 1), gaps, st);
            stalls += st;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (name_valid_out !== 1'b1 && n < 40) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s_valid_timeout got=%b required=1", tag, name_valid_out);
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [EW+1:0] v;
        v = {name_valid_out, comp_ready_out, name_words_out, name_len_out, name_overflow_out};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s got=%h required=0", tag, v);
        end
    endtask

    task automatic test_reset;
        rst_n_in      = 1'b0;
        comp_valid_in = 1'b0;
        comp_word_in  = '0;
        comp_last_in  = 1'b0;
        name_ready_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset_outputs");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        checks++;
        if (comp_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_first_edge got=%b required=0", comp_ready_out);
        end
        @(posedge clk_in); #1;
        checks++;
        if (comp_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_first_edge got=%b required=1", comp_ready_out);
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] w[$];
        logic [EW-1:0] exp;
        int st;
        w = '{32'h11, 32'h22, 32'h33};
        exp = model(w);
        name_ready_in = 1'b1;
        send_name(w, 1'b0, 1'b1, st);
        checks++;
        if ({name_valid_out, comp_ready_out} !== 2'b00) begin
            errors++;
            $display("FAIL basic_one_cycle got=valid_%b_ready_%b required=valid_0_ready_0", name_valid_out, comp_ready_out);
        end
        @(posedge clk_in); #1;
        checks++;
        if (name_valid_out !== 1'b1 || {name_words_out, name_len_out, name_overflow_out} !== exp) begin
            errors++;
            $display("FAIL basic_two_cycle got=%b_%h required=1_%h", name_valid_out,
                     {name_words_out, name_len_out, name_overflow_out}, exp);
        end
    endtask

    task automatic test_overflow;
        logic [W-1:0] w[$];
        logic [EW-1:0] exp;
        int st;
        for (int i = 0; i < 10; i++) w.push_back(W'(32'hA0 + i));
        exp = model(w);
        name_ready_in = 1'b1;
        send_name(w, 1'b0, 1'b1, st);
        checks++;
        if (st !== 0) begin
            errors++;
            $display("FAIL overflow_ready_stalls got=%0d required=0", st);
        end
        wait_valid("overflow");
        checks++;
        if ({name_words_out, name_len_out, name_overflow_out} !== exp) begin
            errors++;
            $display("FAIL overflow_name got=%h required=%h", {name_words_out, name_len_out, name_overflow_out}, exp);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_backpressure;
        logic [W-1:0] a[$];
        logic [W-1:0] b[$];
        logic [EW-1:0] exp_a;
        logic [EW-1:0] exp_b;
        int st;
        for (int i = 0; i < 3; i++) a.push_back($urandom);
        for (int i = 0; i < 2; i++) b.push_back($urandom);
        exp_a = model(a);
        exp_b = model(b);
        name_ready_in = 1'b0;
        send_name(a, 1'b0, 1'b1, st);
        wait_valid("bp_first");
        send_name(b, 1'b0, 1'b1, st);
        checks++;
        if (comp_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_after_last got=%b required=0", comp_ready_out);
        end
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if ({name_valid_out, comp_ready_out, name_words_out, name_len_out, name_overflow_out} !== {2'b10, exp_a}) begin
            errors++;
            $display("FAIL bp_first_held got=%h required=%h",
                     {name_valid_out, comp_ready_out, name_words_out, name_len_out, name_overflow_out}, {2'b10, exp_a});
        end
        name_ready_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (name_valid_out !== 1'b1 || {name_words_out, name_len_out, name_overflow_out} !== exp_b) begin
            errors++;
            $display("FAIL bp_second_no_gap got=%b_%h required=1_%h", name_valid_out,
                     {name_words_out, name_len_out, name_overflow_out}, exp_b);
        end
        @(posedge clk_in); #1;
        checks++;
        if (name_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained got=%b required=0", name_valid_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] w[$];
        int st;
        name_ready_in = 1'b1;
        consume_cyc_q.delete();
        for (int n = 0; n < 4; n++) begin
            w.delete();
            for (int i = 0; i < M; i++) w.push_back($urandom);
            send_name(w, 1'b0, 1'b1, st);
        end
        wait_valid("b2b");
        @(posedge clk_in); #1;
        checks++;
        if (consume_cyc_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got=%0d required=4", consume_cyc_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (consume_cyc_q[i] - consume_cyc_q[i-1] != 9) begin
                    errors++;
                    $display("FAIL b2b_spacing got=%0d required=9", consume_cyc_q[i] - consume_cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] w[$];
        logic [W-1:0] one[$];
        logic [EW-1:0] exp;
        int st;
        name_ready_in = 1'b1;
        drive_word(32'h5001, 1'b0, 1'b0, st);
        drive_word(32'h5002, 1'b0, 1'b0, st);
        rst_n_in = 1'b0;
        #1;
        check_all_zero("mid_name_reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        one = '{32'hBEEF};
        exp = model(one);
        send_name(one, 1'b0, 1'b1, st);
        @(posedge clk_in); #1;
        checks++;
        if (name_valid_out !== 1'b1 || {name_words_out, name_len_out, name_overflow_out} !== exp) begin
            errors++;
            $display("FAIL single_word got=%b_%h required=1_%h", name_valid_out,
                     {name_words_out, name_len_out, name_overflow_out}, exp);
        end
        @(posedge clk_in); #1;
        name_ready_in = 1'b0;
        w = '{32'h7001, 32'h7002};
        send_name(w, 1'b0, 1'b0, st);
        wait_valid("mid_hold");
        rst_n_in = 1'b0;
        #1;
        check_all_zero("mid_hold_reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        name_ready_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (name_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_name_emitted got=%b required=0", name_valid_out);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] w[$];
        int st;
        int n;
        for (int t = 0; t < 12; t++) begin
            w.delete();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) w.push_back($urandom);
            send_name(w, 1'b1, 1'b1, st);
        end
        name_ready_in = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk_in); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain got=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
